// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider: op encodings, FSM states,
// iteration constants and the final sign/special-case correction.
package div_pkg;

   localparam int DIV_XLEN  = 32;
   localparam int DIV_ITERS = DIV_XLEN;
   localparam int DIV_CNT_W = $clog2(DIV_ITERS);

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Applies sign correction to the magnitude results, then overrides with the
   // RISC-V defined values for divide-by-zero and signed overflow.
   function automatic logic [DIV_XLEN-1:0] div_fix(
      input logic                is_rem,
      input logic                dz,
      input logic                ovf,
      input logic                qneg,
      input logic                rneg,
      input logic [DIV_XLEN-1:0] quo,
      input logic [DIV_XLEN-1:0] rem,
      input logic [DIV_XLEN-1:0] dvd
   );
      logic [DIV_XLEN-1:0] q;
      logic [DIV_XLEN-1:0] r;
      q = qneg ? -quo : quo;
      r = rneg ? -rem : rem;
      if (dz) begin
         q = '1;
         r = dvd;
      end else if (ovf) begin
         q = {1'b1, {(DIV_XLEN-1){1'b0}}};
         r = '0;
      end
      return is_rem ? r : q;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem, quo} left, trial-subtract the
// divisor and keep the difference when it does not go negative.
module div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem,
   input  logic [W-1:0] quo,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] rem_nxt,
   output logic [W-1:0] quo_nxt
);

   logic [W:0] sh;
   logic       ge;

   always_comb begin
      sh = {rem, quo[W-1]};
      ge = (sh >= {1'b0, divisor});
      // The kept remainder is always below the divisor, so W bits suffice.
      rem_nxt = ge ? W'(sh - {1'b0, divisor}) : sh[W-1:0];
      quo_nxt = {quo[W-2:0], ge};
   end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass CALC.
module div_unit
   import div_pkg::*;
#(
   parameter int XLEN  = DIV_XLEN,
   parameter int ITERS = XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            busy,
   output logic            valid,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   localparam int CNT_W = $clog2(ITERS);

   div_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [XLEN-1:0] dvd_q, dvd_d;
   logic            is_rem_q, is_rem_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;
   logic            dz_q, dz_d;
   logic            ovf_q, ovf_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] res_q, res_d;
   logic [4:0]      rdo_q, rdo_d;

   logic [XLEN-1:0] rem_n, quo_n;
   logic            in_signed, in_s1, in_s2, in_dz, in_ovf;

   div_step #(.W(XLEN)) u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .divisor (dvs_q),
      .rem_nxt (rem_n),
      .quo_nxt (quo_n)
   );

   always_comb begin
      in_signed = ~op[0];
      in_s1     = in_signed & rs1[XLEN-1];
      in_s2     = in_signed & rs2[XLEN-1];
      in_dz     = (rs2 == '0);
      in_ovf    = in_signed & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      dvd_d    = dvd_q;
      is_rem_d = is_rem_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      ovf_d    = ovf_q;
      rd_d     = rd_q;
      res_d    = res_q;
      rdo_d    = rdo_q;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               is_rem_d = op[1];
               rd_d     = rd_in;
               quo_d    = in_s1 ? -rs1 : rs1;
               dvs_d    = in_s2 ? -rs2 : rs2;
               dvd_d    = rs1;
               qneg_d   = in_s1 ^ in_s2;
               rneg_d   = in_s1;
               dz_d     = in_dz;
               ovf_d    = in_ovf;
               rem_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
`ifdef DIV_FAST_SPECIAL_EN
               if (in_dz || in_ovf) begin
                  state_d = DONE;
                  res_d   = div_fix(op[1], in_dz, in_ovf, 1'b0, 1'b0, '0, '0, rs1);
                  rdo_d   = rd_in;
               end
`else
`endif
            end
         end
         CALC: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               rem_d = rem_n;
               quo_d = quo_n;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(ITERS-1)) begin
                  state_d = DONE;
                  res_d   = div_fix(is_rem_q, dz_q, ovf_q, qneg_q, rneg_q, quo_n, rem_n, dvd_q);
                  rdo_d   = rd_q;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         dvd_q    <= '0;
         is_rem_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         ovf_q    <= 1'b0;
         rd_q     <= '0;
         res_q    <= '0;
         rdo_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvs_q    <= dvs_d;
         dvd_q    <= dvd_d;
         is_rem_q <= is_rem_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         ovf_q    <= ovf_d;
         rd_q     <= rd_d;
         res_q    <= res_d;
         rdo_q    <= rdo_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign valid  = (state_q == DONE);
   assign result = res_q;
   assign rd_out = rdo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus scoreboard, with flush,
// ignored-start and asynchronous-reset sequences.
module tb_div_unit;
   import div_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, valid;
   logic [31:0] result;
   logic [4:0]  rd_out;

   div_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
      .rd_in(rd_in), .flush(flush), .busy(busy), .valid(valid),
      .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;

`ifdef DIV_FAST_SPECIAL_EN
   localparam int SPEC_LAT = 0;
`else
   localparam int SPEC_LAT = 32;
`endif

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      bit          special;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
   } sb_t;

   sb_t         sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_res = '0;
   logic [4:0]  last_rd = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = 32'd0;
      end else if (!o[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return o[1] ? r : q;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit special);
      int  cyc;
      sb_t e;
      @(negedge clk);
      op = o; rs1 = a; rs2 = b; rd_in = rd; start = 1'b1;
      sb_q.push_back('{res: exp, rd: rd});
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0;
      while (!valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!valid) begin
         chk("timeout", 32'd0, 32'd1);
         sb_q.delete();
      end else begin
         chk("latency", cyc, special ? SPEC_LAT : 32);
         if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
         end else begin
            e = sb_q.pop_front();
            chk("result", result, e.res);
            chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            last_res = e.res;
            last_rd  = e.rd;
         end
         @(posedge clk);
         #1;
         chk("valid_pulse", {31'd0, valid}, 32'd0);
         chk("idle_busy", {31'd0, busy}, 32'd0);
      end
   endtask

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          5'd3,  32'd14,         1'b0};
      tbl[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          5'd4,  32'd2,          1'b0};
      tbl[2]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFD,  1'b0};
      tbl[3]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  1'b0};
      tbl[4]  = '{DIV_OP_DIVU, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'h7FFF_FFFC,  1'b0};
      tbl[5]  = '{DIV_OP_DIV,  32'h1234_5678,  32'd0,          5'd8,  32'hFFFF_FFFF,  1'b1};
      tbl[6]  = '{DIV_OP_REM,  32'h1234_5678,  32'd0,          5'd9,  32'h1234_5678,  1'b1};
      tbl[7]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h8000_0000,  1'b1};
      tbl[8]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          1'b1};
      tbl[9]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd0,          5'd12, 32'hFFFF_FFFF,  1'b1};
      tbl[10] = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd0,          5'd13, 32'hFFFF_FFF9,  1'b1};
      tbl[11] = '{DIV_OP_REMU, 32'd5,          32'd0,          5'd14, 32'd5,          1'b1};
      tbl[12] = '{DIV_OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,          1'b0};
      tbl[13] = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd31, 32'd1,          1'b0};

      // reset state
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rd", {27'd0, rd_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++)
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, tbl[i].special);

      for (int i = 0; i < 6; i++) begin
         logic [1:0]  o;
         logic [31:0] a, b;
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         run_op(o, a, b, 5'(i + 16), model(o, a, b),
                (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      end

      // ignored start mid-flight, then flush
      @(negedge clk);
      op = DIV_OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd20; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = (c == 3);
         if (c == 3) begin
            op = DIV_OP_DIV; rs1 = 32'd5; rs2 = 32'd1; rd_in = 5'd21;
         end
         flush = (c == 10);
         @(posedge clk);
         #1;
         if (c < 10) chk("flush_busy_hold", {31'd0, busy}, 32'd1);
         chk("flush_no_valid", {31'd0, valid}, 32'd0);
      end
      flush = 1'b0;
      chk("flush_idle", {31'd0, busy}, 32'd0);
      chk("flush_result_kept", result, last_res);
      chk("flush_rd_kept", {27'd0, rd_out}, {27'd0, last_rd});
      run_op(DIV_OP_DIVU, 32'd100, 32'd7, 5'd22, 32'd14, 1'b0);

      // asynchronous reset mid-CALC
      @(negedge clk);
      op = DIV_OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; rd_in = 5'd23; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_valid", {31'd0, valid}, 32'd0);
      chk("arst_result", result, 32'd0);
      chk("arst_rd", {27'd0, rd_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_no_valid", {31'd0, valid}, 32'd0);
      run_op(DIV_OP_REMU, 32'd100, 32'd7, 5'd24, 32'd2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
